alu_issue_station: RTL and testbench



---
 rtl/alu_rs_pkg.sv | 47 ++++
 rtl/alu_issue_station_if.sv | 43 ++++
 rtl/alu_rs_picker.sv | 22 ++
 rtl/alu_issue_station.sv | 144 ++++++++++++++
 tb/tb_alu_issue_station.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_pkg.sv
// Shared widths, opcode encoding and entry layout for the ALU issue station.
package alu_rs_pkg;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 3;
    localparam int TAG_W  = 2;
    localparam int OP_W   = 3;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic [TAG_W-1:0]  tag;
        logic              rdy;
    } rs_opnd_t;

    // Opcode kept as raw bits so unlisted encodings pass through untouched.
    typedef struct packed {
        logic             valid;
        logic [OP_W-1:0]  opcode;
        logic [TAG_W-1:0] rob_idx;
        rs_opnd_t         op1;
        rs_opnd_t         op2;
    } rs_entry_t;

    // A waiting operand whose producer tag is on the CDB picks up the value.
    function automatic rs_opnd_t snoop(input rs_opnd_t o, input logic cdb_v,
                                       input logic [TAG_W-1:0] cdb_t,
                                       input logic [DATA_W-1:0] cdb_v_data);
        rs_opnd_t r;
        r = o;
        if (cdb_v && !o.rdy && (o.tag == cdb_t)) begin
            r.val = cdb_v_data;
            r.rdy = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_station_if.sv
// Dispatch, CDB snoop and ALU launch signals of the ALU issue station.
interface alu_issue_station_if;
    import alu_rs_pkg::*;

    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_opcode;
    logic [DATA_W-1:0] disp_val1;
    logic [DATA_W-1:0] disp_val2;
    logic [TAG_W-1:0]  disp_tag1;
    logic [TAG_W-1:0]  disp_tag2;
    logic              disp_rdy1;
    logic              disp_rdy2;
    logic [TAG_W-1:0]  disp_rob_idx;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              flush;
    logic              alu_busy;
    logic              alu_start;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_val1;
    logic [DATA_W-1:0] alu_val2;
    logic [TAG_W-1:0]  alu_rob_idx;
    logic [CNT_W-1:0]  count;

    // Dispatch/ALU side driving the station.
    modport master (
        output disp_valid, disp_opcode, disp_val1, disp_val2, disp_tag1, disp_tag2,
               disp_rdy1, disp_rdy2, disp_rob_idx, cdb_valid, cdb_tag, cdb_value,
               flush, alu_busy,
        input  disp_ready, alu_start, alu_opcode, alu_val1, alu_val2, alu_rob_idx, count
    );

    // The station itself.
    modport slave (
        input  disp_valid, disp_opcode, disp_val1, disp_val2, disp_tag1, disp_tag2,
               disp_rdy1, disp_rdy2, disp_rob_idx, cdb_valid, cdb_tag, cdb_value,
               flush, alu_busy,
        output disp_ready, alu_start, alu_opcode, alu_val1, alu_val2, alu_rob_idx, count
    );

endinterface

// File: rtl/alu_rs_picker.sv
// Oldest-ready selector: lowest set index of the ready vector.
module alu_rs_picker
    import alu_rs_pkg::*;
(
    input  logic [DEPTH-1:0] ready_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scan from youngest to oldest so the oldest ready entry wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_station.sv
// ALU reservation station: collapsing queue of dispatched micro-ops with CDB
// wake-up and oldest-ready launch into the single ALU.
module alu_issue_station
    import alu_rs_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    alu_issue_station_if.slave  rs
);

    rs_entry_t         entries_q [DEPTH];
    rs_entry_t         entries_d [DEPTH];
    rs_entry_t         woken     [DEPTH+1];
    rs_entry_t         new_entry;
    rs_entry_t         pick_entry;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  wr_slot;
    logic              alu_start_q, alu_start_d;
    logic [OP_W-1:0]   alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0] alu_val1_q, alu_val1_d;
    logic [DATA_W-1:0] alu_val2_q, alu_val2_d;
    logic [TAG_W-1:0]  alu_rob_idx_q, alu_rob_idx_d;
    logic [DEPTH-1:0]  rdy_vec;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              disp_ready;
    logic              accept;
    logic              launch;

    // Registered readiness only: an operand woken this edge selects next cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = entries_q[i].valid & entries_q[i].op1.rdy & entries_q[i].op2.rdy;
        end
    end

    alu_rs_picker u_picker (
        .ready_i (rdy_vec),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign pick_entry = entries_q[pick_idx];
    assign disp_ready = (count_q < CNT_W'(DEPTH));
    assign accept     = rs.disp_valid && disp_ready && !rs.flush;
    // The !alu_start term covers the cycle before the ALU raises busy.
    assign launch     = !rs.alu_busy && !alu_start_q && pick_found && !rs.flush;
    assign wr_slot    = count_q - CNT_W'(launch);

    // Apply CDB wake-up to every stored entry; slot DEPTH is the empty fill-in.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = entries_q[i];
            if (entries_q[i].valid) begin
                woken[i].op1 = snoop(entries_q[i].op1, rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
                woken[i].op2 = snoop(entries_q[i].op2, rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
            end
        end
        woken[DEPTH] = '0;
    end

    // Incoming entry, with same-cycle CDB bypass on waiting operands.
    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.opcode  = rs.disp_opcode;
        new_entry.rob_idx = rs.disp_rob_idx;
        new_entry.op1     = snoop('{val: rs.disp_val1, tag: rs.disp_tag1, rdy: rs.disp_rdy1},
                                  rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
        new_entry.op2     = snoop('{val: rs.disp_val2, tag: rs.disp_tag2, rdy: rs.disp_rdy2},
                                  rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
    end

    // Collapse over the launched slot, then drop the new entry after the survivors.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (launch && (CNT_W'(i) >= CNT_W'(pick_idx))) begin
                entries_d[i] = woken[i+1];
            end else begin
                entries_d[i] = woken[i];
            end
            if (accept && (CNT_W'(i) == wr_slot)) begin
                entries_d[i] = new_entry;
            end
            if (rs.flush) begin
                entries_d[i] = '0;
            end
        end
        if (rs.flush) begin
            count_d = '0;
        end else begin
            count_d = count_q - CNT_W'(launch) + CNT_W'(accept);
        end
    end

    // Launch payload is held between launches; the start pulse lasts one cycle.
    always_comb begin
        alu_start_d   = launch;
        alu_opcode_d  = alu_opcode_q;
        alu_val1_d    = alu_val1_q;
        alu_val2_d    = alu_val2_q;
        alu_rob_idx_d = alu_rob_idx_q;
        if (launch) begin
            alu_opcode_d  = pick_entry.opcode;
            alu_val1_d    = pick_entry.op1.val;
            alu_val2_d    = pick_entry.op2.val;
            alu_rob_idx_d = pick_entry.rob_idx;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q       <= '0;
            alu_start_q   <= 1'b0;
            alu_opcode_q  <= '0;
            alu_val1_q    <= '0;
            alu_val2_q    <= '0;
            alu_rob_idx_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q       <= count_d;
            alu_start_q   <= alu_start_d;
            alu_opcode_q  <= alu_opcode_d;
            alu_val1_q    <= alu_val1_d;
            alu_val2_q    <= alu_val2_d;
            alu_rob_idx_q <= alu_rob_idx_d;
        end
    end

    assign rs.disp_ready  = disp_ready;
    assign rs.count       = count_q;
    assign rs.alu_start   = alu_start_q;
    assign rs.alu_opcode  = alu_opcode_q;
    assign rs.alu_val1    = alu_val1_q;
    assign rs.alu_val2    = alu_val2_q;
    assign rs.alu_rob_idx = alu_rob_idx_q;

endmodule

// File: tb/tb_alu_issue_station.sv
// Scoreboard bench for the ALU issue station.
module tb_alu_issue_station;
    import alu_rs_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy_hold = 1'b0;
    logic mimic_busy = 1'b0;
    logic mimic_en = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_start = 0;
    bit   have_last = 1'b0;
    logic [10:0] exp_q[$];

    alu_issue_station_if ifc ();

    alu_issue_station dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rs    (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ifc.alu_busy = busy_hold | mimic_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] pk(input logic [2:0] op, input logic [2:0] v1,
                                       input logic [2:0] v2, input logic [1:0] rob);
        return {op, v1, v2, rob};
    endfunction

    // ALU model: busy for the cycle after each start (2-cycle ALU).
    initial begin
        logic s;
        forever begin
            @(negedge clk);
            s = ifc.alu_start & mimic_en;
            @(posedge clk);
            #1 mimic_busy = s;
        end
    end

    // Output side of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && ifc.alu_start) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_start", 1, 0);
            end else begin
                chk("launch_payload",
                    {21'd0, ifc.alu_opcode, ifc.alu_val1, ifc.alu_val2, ifc.alu_rob_idx},
                    {21'd0, exp_q.pop_front()});
            end
            if (mimic_en && have_last) chk("launch_gap", cyc - last_start, 3);
            last_start = cyc;
            have_last  = 1'b1;
        end
    end

    task automatic disp(input logic [2:0] op, input logic [2:0] v1, input logic [1:0] t1,
                        input logic r1, input logic [2:0] v2, input logic [1:0] t2,
                        input logic r2, input logic [1:0] rob);
        ifc.disp_valid   = 1'b1;
        ifc.disp_opcode  = op;
        ifc.disp_val1    = v1;
        ifc.disp_tag1    = t1;
        ifc.disp_rdy1    = r1;
        ifc.disp_val2    = v2;
        ifc.disp_tag2    = t2;
        ifc.disp_rdy2    = r2;
        ifc.disp_rob_idx = rob;
        @(negedge clk);
        ifc.disp_valid   = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int k = 0; k < max_cyc && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.disp_valid = 0; ifc.disp_opcode = 0; ifc.disp_val1 = 0; ifc.disp_val2 = 0;
        ifc.disp_tag1 = 0; ifc.disp_tag2 = 0; ifc.disp_rdy1 = 0; ifc.disp_rdy2 = 0;
        ifc.disp_rob_idx = 0; ifc.cdb_valid = 0; ifc.cdb_tag = 0; ifc.cdb_value = 0;
        ifc.flush = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_count", ifc.count, 0);
        chk("rst_ready", ifc.disp_ready, 1);
        chk("rst_start", ifc.alu_start, 0);
        chk("rst_payload", {ifc.alu_opcode, ifc.alu_val1, ifc.alu_val2, ifc.alu_rob_idx}, 0);

        // Simple ready ADD: start visible two negedges after dispatch edge.
        exp_q.push_back(pk(OP_ADD, 3, 2, 1));
        disp(OP_ADD, 3, 0, 1, 2, 0, 1, 1);
        chk("add_count1", ifc.count, 1);
        chk("add_start_early", ifc.alu_start, 0);
        @(negedge clk);
        chk("add_start", ifc.alu_start, 1);
        chk("add_count0", ifc.count, 0);
        @(negedge clk);
        chk("add_pulse_len", ifc.alu_start, 0);

        // Operand 2 waits on tag 2, woken by the CDB.
        exp_q.push_back(pk(OP_SUB, 6, 5, 3));
        disp(OP_SUB, 6, 0, 1, 0, 2, 0, 3);
        repeat (2) @(negedge clk);
        chk("sub_wait_start", ifc.alu_start, 0);
        chk("sub_wait_count", ifc.count, 1);
        ifc.cdb_valid = 1; ifc.cdb_tag = 2; ifc.cdb_value = 5;
        @(negedge clk);
        ifc.cdb_valid = 0;
        chk("wake_plus1", ifc.alu_start, 0);
        @(negedge clk);
        chk("wake_plus2", ifc.alu_start, 1);
        @(negedge clk);

        // Dispatch and broadcast in the same cycle: bypass.
        exp_q.push_back(pk(OP_AND, 5, 4, 2));
        ifc.cdb_valid = 1; ifc.cdb_tag = 1; ifc.cdb_value = 5;
        disp(OP_AND, 0, 1, 0, 4, 0, 1, 2);
        ifc.cdb_valid = 0;
        chk("bypass_early", ifc.alu_start, 0);
        @(negedge clk);
        chk("bypass_start", ifc.alu_start, 1);
        wait_drain(20);

        // Fill while busy, overflow ignored, then drain in order with a 2-cycle ALU.
        have_last = 1'b0;
        busy_hold = 1'b1;
        disp(OP_ADD, 1, 0, 1, 1, 0, 1, 0);
        disp(OP_SUB, 2, 0, 1, 1, 0, 1, 1);
        disp(OP_AND, 3, 0, 1, 2, 0, 1, 2);
        disp(OP_OR,  4, 0, 1, 5, 0, 1, 3);
        chk("full_count", ifc.count, 4);
        chk("full_ready", ifc.disp_ready, 0);
        disp(OP_XOR, 7, 0, 1, 7, 0, 1, 2);
        chk("full_ignored", ifc.count, 4);
        chk("busy_no_start", ifc.alu_start, 0);
        exp_q.push_back(pk(OP_ADD, 1, 1, 0));
        exp_q.push_back(pk(OP_SUB, 2, 1, 1));
        exp_q.push_back(pk(OP_AND, 3, 2, 2));
        exp_q.push_back(pk(OP_OR,  4, 5, 3));
        mimic_en = 1'b1;
        busy_hold = 1'b0;
        wait_drain(40);
        @(negedge clk);
        chk("drained_count", ifc.count, 0);
        mimic_en = 1'b0;
        repeat (3) @(negedge clk);

        // Older waiting entry is bypassed by a younger ready one.
        exp_q.push_back(pk(OP_ADD, 2, 2, 1));
        exp_q.push_back(pk(OP_XOR, 1, 7, 0));
        disp(OP_XOR, 1, 0, 1, 0, 3, 0, 0);
        disp(OP_ADD, 2, 0, 1, 2, 0, 1, 1);
        ifc.cdb_valid = 1; ifc.cdb_tag = 2; ifc.cdb_value = 6;
        @(negedge clk);
        ifc.cdb_valid = 0;
        for (int k = 0; k < 10 && exp_q.size() > 1; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("ooo_one_left", exp_q.size(), 1);
        chk("ooo_count", ifc.count, 1);
        ifc.cdb_valid = 1; ifc.cdb_tag = 3; ifc.cdb_value = 7;
        @(negedge clk);
        ifc.cdb_valid = 0;
        wait_drain(10);

        // Flush with pending ready ops: nothing launches.
        busy_hold = 1'b1;
        disp(OP_ADD, 1, 0, 1, 2, 0, 1, 0);
        disp(OP_SUB, 3, 0, 1, 4, 0, 1, 1);
        disp(OP_OR,  5, 0, 1, 6, 0, 1, 2);
        chk("pre_flush_count", ifc.count, 3);
        ifc.flush = 1'b1;
        busy_hold = 1'b0;
        @(negedge clk);
        ifc.flush = 1'b0;
        chk("flush_count", ifc.count, 0);
        chk("flush_start", ifc.alu_start, 0);
        repeat (4) @(negedge clk);
        chk("flush_after_count", ifc.count, 0);

        // Asynchronous reset while two entries are held.
        busy_hold = 1'b1;
        disp(OP_XOR, 1, 0, 1, 2, 0, 1, 0);
        disp(OP_SUB, 3, 0, 1, 4, 0, 1, 1);
        chk("pre_rst_count", ifc.count, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", ifc.count, 0);
        chk("arst_start", ifc.alu_start, 0);
        chk("arst_ready", ifc.disp_ready, 1);
        chk("arst_payload", {ifc.alu_opcode, ifc.alu_val1, ifc.alu_val2, ifc.alu_rob_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        busy_hold = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_count", ifc.count, 0);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
